load_store_unit: RTL
====================

# load_store_unit

Initiator side of the data-memory interface. Sits between the execute stage and the word-addressed data memory. Accepts one load or store request at a time, drives the memory's address, write-data, memWrite and memRead signals, and returns sign- or zero-extended load data. Byte and halfword stores are done by read-modify-write because the memory has no byte enables.

## Interface
Parameters:
- DEPTH_WORDS, 32: number of memory words. A word index ≥ DEPTH_WORDS is an access fault.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req  in  1  request strobe; sampled only when ready=1.
- isStore  in  1  1 = store, 0 = load.
- funct3  in  3  access type, RISC-V encoding. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- byteAddress  in  32  byte address of the access.
- storeData  in  32  store source; the low byte or halfword is used for SB/SH.
- ready  out  1  1 in IDLE only.
- done  out  1  one-cycle completion pulse.
- loadData  out  32  extended load result; valid while done=1 on a load, 0 otherwise.
- error  out  1  valid with done. Set for misaligned access, out-of-range access or illegal funct3.
- memAddress  out  32  word index, equal to byteAddress>>2.
- memWriteData  out  32  word to write.
- memWrite  out  1  memory writes memWriteData at the posedge where this is 1.
- memRead  out  1  read enable.
- memReadData  in  32  combinational read data from the memory for memAddress.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - ready=1.
  - On req=1, latch isStore, funct3, byteAddress and storeData.
  - Check the request:
    - misaligned: LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0;
    - out of range: addr[31:2] ≥ DEPTH_WORDS;
    - illegal funct3.
  - Any check fails → RESP with error=1. No memory access takes place.
  - Otherwise:
    - loads and SB/SH → READ;
    - SW → WRITE.
- READ:
  - Drive memRead=1 and memAddress.
  - At the posedge, capture memReadData into an internal word register.
  - Load → RESP. SB/SH → WRITE.
- WRITE:
  - Drive memWrite=1.
  - For SW, memWriteData = storeData.
  - For SB/SH, memWriteData = the captured word with the selected lane replaced by storeData[7:0] or storeData[15:0]. Other lanes are unchanged.
  - → RESP.
- RESP:
  - done=1.
  - For a load, loadData = the selected lane, extended. LB/LH sign-extend; LBU/LHU/LW zero-extend or pass through.
  - → IDLE.
- Lanes are little-endian. Byte k is bits [8k+7:8k] with k = addr[1:0]. A halfword uses bits [15:0] when addr[1]=0 and bits [31:16] when addr[1]=1.
- Memory outputs are registered or state-decoded. memRead and memWrite are never both 1. Both are 0 outside READ and WRITE, and memAddress/memWriteData are 0 in IDLE.
- A req arriving while ready=0 is ignored; it is not queued.

## Timing
- Latency, counted from the accept edge E0 (the edge at which req is sampled in IDLE):
  - LW/LH/LB: READ in cycle 1, done in cycle 2.
  - SW: WRITE in cycle 1 (memory written at E1), done in cycle 2.
  - SB/SH: READ in cycle 1, WRITE in cycle 2 (memory written at E2), done in cycle 3.
  - Error: done+error in cycle 1.
- ready returns to 1 in the cycle after done. The next req can be accepted at the end of that cycle.
- Reset values: state IDLE, ready=1 once reset is released, all other outputs 0, latches 0.
- Reset mid-operation:
  - At the next posedge, return to IDLE with no done.
  - If reset is asserted during WRITE, the memory still commits that write at the same edge. This is accepted behaviour.
  - If reset is asserted during READ of an SB/SH, no write occurs.
- A req that coincides with reset is dropped.

## Structure
- Package lsu_pkg holds:
  - the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum (IDLE, READ, WRITE, RESP).
- One combinational sub-module, lsu_lane_align:
  - inputs: word, addr[1:0], funct3, storeData;
  - outputs: extracted+extended load value and merged store word.
  - Shared by the READ and WRITE paths; unit-testable alone.

## Test plan
- Preload word 3 = 0x8070_60F0. LB at 0x0C → done at cycle 2, loadData 0xFFFF_FFF0. LBU at 0x0D → 0x0000_0060. LH at 0x0E → 0xFFFF_8070.
- SW 0xDEAD_BEEF at 0x10 → memWrite=1 in cycle 1 with memAddress 4 and memWriteData 0xDEAD_BEEF. done at cycle 2. A following LW at 0x10 returns 0xDEAD_BEEF.
- With word 4 = 0xDEAD_BEEF, SB 0x12 at 0x11 → READ then WRITE with memWriteData 0xDEAD_12EF. done at cycle 3, and memWrite is 1 for exactly one cycle.
- Fault requests: LW at 0x0000_0006 → done+error in cycle 1 with no memRead/memWrite pulse. SH at 0x0000_0081 → error. LW at 0x80 with DEPTH_WORDS=32 → error.
- Hold req=1 with a second request during cycles 1–2 of an SB → the second request is ignored, and only one done is seen per accepted request.
- Assert reset during READ of an SH → next cycle is IDLE with all outputs 0, no memWrite and no done; memory contents are unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// funct3 access encodings, controller state enum, request validity helpers.
// Pure declarations; no logic of its own.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Stores only have B/H/W; loads also have the unsigned B/H forms.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  // Halfwords need an even address, words need a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if ((f3 == F3_H) || (f3 == F3_HU)) bad = a[0];
    if (f3 == F3_W) bad = (a != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request and data-memory signal bundle for the load/store unit.
// master = execute stage plus memory model, slave = the load/store unit.
// No storage; the unit's ready/done pair governs the request handshake.
interface lsu_if;
  logic        req;
  logic        isStore;
  logic [2:0]  funct3;
  logic [31:0] byteAddress;
  logic [31:0] storeData;
  logic        ready;
  logic        done;
  logic [31:0] loadData;
  logic        error;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memReadData;

  modport master (
    output req, isStore, funct3, byteAddress, storeData, memReadData,
    input  ready, done, loadData, error, memAddress, memWriteData, memWrite, memRead
  );

  modport slave (
    input  req, isStore, funct3, byteAddress, storeData, memReadData,
    output ready, done, loadData, error, memAddress, memWriteData, memWrite, memRead
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane extraction with extension, and store-lane merge into a word.
// Purely combinational, zero latency.
// No handshake; outputs follow inputs.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_val_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane and extend it according to the access type.
  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = word_i[{addr_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    load_val_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val_o = {24'h0, byte_sel};
      F3_H:    load_val_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val_o = {16'h0, half_sel};
      default: load_val_o = word_i;
    endcase
  end

  // Replace only the addressed lane; a full-word store takes the source as is.
  always_comb begin
    store_word_o = word_i;
    case (funct3_i)
      F3_B:    store_word_o[{addr_i, 3'b000} +: 8] = store_data_i[7:0];
      F3_H:    store_word_o[{addr_i[1], 4'b0000} +: 16] = store_data_i[15:0];
      default: store_word_o = store_data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator to a word-addressed memory; B/H stores by read-modify-write.
// Latency: LW/LH/LB and SW done 2 cycles after accept, SB/SH 3, faulting request 1.
// ready only in IDLE; req while busy is dropped, never queued.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32
) (
  input logic  clock,
  input logic  reset,
  lsu_if.slave bus
);

  lsu_state_e  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;

  logic        req_fault;
  logic [31:0] load_val;
  logic [31:0] store_word;

  // Incoming request checks: bad encoding, bad alignment, word index beyond memory.
  assign req_fault = !f3_legal(bus.isStore, bus.funct3)
                   || misaligned(bus.funct3, bus.byteAddress[1:0])
                   || ({2'b00, bus.byteAddress[31:2]} >= 32'(DEPTH_WORDS));

  lsu_lane_align u_align (
    .word_i       (word_q),
    .addr_i       (addr_q[1:0]),
    .funct3_i     (funct3_q),
    .store_data_i (sdata_q),
    .load_val_o   (load_val),
    .store_word_o (store_word)
  );

  // State and request latches; reset drops any in-flight access without a done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      sdata_q    <= 32'h0;
      word_q     <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      word_q     <= word_d;
      err_q      <= err_d;
    end
  end

  // Next state: faults skip memory entirely, SW writes directly, everything else reads first.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    word_d     = word_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          is_store_d = bus.isStore;
          funct3_d   = bus.funct3;
          addr_d     = bus.byteAddress;
          sdata_d    = bus.storeData;
          err_d      = req_fault;
          if (req_fault)                            state_d = RESP;
          else if (bus.isStore && bus.funct3 == F3_W) state_d = WRITE;
          else                                      state_d = READ;
        end
      end
      READ: begin
        word_d  = bus.memReadData;
        state_d = is_store_q ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state so memRead/memWrite are mutually exclusive by construction.
  assign bus.ready        = (state_q == IDLE);
  assign bus.done         = (state_q == RESP);
  assign bus.error        = (state_q == RESP) && err_q;
  assign bus.loadData     = ((state_q == RESP) && !is_store_q && !err_q) ? load_val : 32'h0;
  assign bus.memRead      = (state_q == READ);
  assign bus.memWrite     = (state_q == WRITE);
  assign bus.memAddress   = ((state_q == READ) || (state_q == WRITE)) ? {2'b00, addr_q[31:2]} : 32'h0;
  assign bus.memWriteData = (state_q == WRITE) ? store_word : 32'h0;

endmodule
